// File: rtl/traffic_controller_n.sv
// traffic_controller_n
//   N-way intersection controller. Exactly one approach owns green/yellow at a
//   time; phases run ALLRED -> GREEN -> YELLOW -> ALLRED with fixed durations.
//   On each ALLRED exit the next approach is the first one with demand,
//   scanning forward from the current approach. With no demand at all, the
//   controller rotates to the next approach on a fixed time plan.
//
//   Optional feature macro: TRAFFIC_PREEMPT_EN
//     Adds emergency preemption. A request cuts short the green on another
//     approach, lets yellow and all-red complete, and then forces green on
//     preempt_dir. Green holds there while the request stays high. Without the
//     macro, preempt/preempt_dir are ignored and preempt_active is tied low.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   demand         per-approach vehicle-present sensors (bit i = approach i)
//   preempt        emergency request (only used with TRAFFIC_PREEMPT_EN)
//   preempt_dir    approach to preempt to; values >= NUM_DIR are ignored
//   lamp           {red,yellow,green} one-hot per approach, approach i at [3i+2:3i]
//   active_dir     approach owning green/yellow (last served during all-red)
//   phase          2'b00 ALLRED, 2'b01 GREEN, 2'b10 YELLOW
//   preempt_active high while a preemption sequence is in progress
module traffic_controller_n #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W      = 8,
  parameter int DIR_W      = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_DIR-1:0]   demand,
  input  logic                 preempt,
  input  logic [DIR_W-1:0]     preempt_dir,
  output logic [3*NUM_DIR-1:0] lamp,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase,
  output logic                 preempt_active
);

  // The encoding doubles as the phase output.
  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);
  localparam logic [CNT_W-1:0] G_END    = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_CYC - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [DIR_W-1:0]   cur, cur_nx;
  logic [DIR_W-1:0]   scan_dir;

  logic [2*NUM_DIR-1:0] demand_dbl;
  logic [NUM_DIR-1:0]   demand_rot;
  int                   scan_off;
  int                   scan_sum;

  // Rotate demand so bit 0 is approach cur+1, take the lowest set bit, and
  // map the offset back to an approach number. No demand gives offset 0,
  // which is the fixed-time step to cur+1.
  always_comb begin
    demand_dbl = {demand, demand};
    demand_rot = demand_dbl[int'(cur) + 1 +: NUM_DIR];
    scan_off   = 0;
    for (int j = NUM_DIR - 1; j >= 0; j--) begin
      if (demand_rot[j]) scan_off = j;
    end
    scan_sum = int'(cur) + 1 + scan_off;
    if (scan_sum >= NUM_DIR) scan_sum = scan_sum - NUM_DIR;
    scan_dir = DIR_W'(scan_sum);
  end

`ifdef TRAFFIC_PREEMPT_EN
  logic             pa_q;
  logic [DIR_W-1:0] pdir_q;
  logic             req;
  logic             chase;
  logic [DIR_W-1:0] target;

  assign req    = preempt && (int'(preempt_dir) < NUM_DIR);
  // A fresh request overrides any earlier latched target.
  assign target = req ? preempt_dir : pdir_q;
  assign chase  = req || pa_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pa_q   <= 1'b0;
      pdir_q <= '0;
    end else if (req) begin
      pa_q   <= 1'b1;
      pdir_q <= preempt_dir;
    end else if (state == GREEN && state_nx == YELLOW && cur == pdir_q) begin
      pa_q   <= 1'b0;
    end
  end

  assign preempt_active = pa_q;
`else
  logic unused_preempt;
  assign unused_preempt = ^{preempt, preempt_dir};
  assign preempt_active = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    cur_nx   = cur;
    unique case (state)
      ALLRED: begin
        if (cnt == AR_END) begin
          state_nx = GREEN;
          cnt_nx   = '0;
          cur_nx   = scan_dir;
`ifdef TRAFFIC_PREEMPT_EN
          if (chase) cur_nx = target;
`endif
        end
      end
      GREEN: begin
`ifdef TRAFFIC_PREEMPT_EN
        if (chase && cur != target) begin
          state_nx = YELLOW;
          cnt_nx   = '0;
        end else if (req && cur == target) begin
          // Hold green on the preempted approach while the request persists.
          cnt_nx   = '0;
        end else
`endif
        if (cnt == G_END) begin
          state_nx = YELLOW;
          cnt_nx   = '0;
        end
      end
      YELLOW: begin
        if (cnt == Y_END) begin
          state_nx = ALLRED;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ALLRED;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments and the asynchronous
  // reset, so outputs drop to all-red the moment reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ALLRED;
      cnt   <= '0;
      cur   <= LAST_DIR;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cur   <= cur_nx;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    lamp = {NUM_DIR{3'b100}};
    case (state)
      GREEN:   lamp[3*int'(cur) +: 3] = 3'b001;
      YELLOW:  lamp[3*int'(cur) +: 3] = 3'b010;
      default: ;
    endcase
  end

  assign active_dir = cur;
  assign phase      = state;

endmodule

// File: tb/tb_traffic_controller_n.sv
// Testbench for traffic_controller_n.
//   dut  : default parameters (4 approaches, 8/4/1), driven with directed and
//          random demand; expected per-cycle outputs come from a slot-level
//          model of the schedule and are queued for a negedge monitor.
//   dut3 : 3 approaches, 5/2/3, full demand; expected outputs come from a
//          closed-form function of cycles since reset release.
module tb_traffic_controller_n;

  localparam int N   = 4;
  localparam int G   = 8;
  localparam int Y   = 4;
  localparam int AR  = 1;
  localparam int N3  = 3;
  localparam int G3  = 5;
  localparam int Y3  = 2;
  localparam int AR3 = 3;

  localparam logic [1:0] PH_AR = 2'b00;
  localparam logic [1:0] PH_G  = 2'b01;
  localparam logic [1:0] PH_Y  = 2'b10;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   demand = '0;
  logic           preempt = 1'b0;
  logic [1:0]     preempt_dir = '0;
  logic [3*N-1:0] lamp;
  logic [1:0]     active_dir;
  logic [1:0]     phase;
  logic           preempt_active;

  logic [3*N3-1:0] lamp3;
  logic [1:0]      active_dir3;
  logic [1:0]      phase3;
  logic            preempt_active3;

  traffic_controller_n dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .demand         (demand),
    .preempt        (preempt),
    .preempt_dir    (preempt_dir),
    .lamp           (lamp),
    .active_dir     (active_dir),
    .phase          (phase),
    .preempt_active (preempt_active)
  );

  traffic_controller_n #(
    .NUM_DIR(N3), .GREEN_CYC(G3), .YELLOW_CYC(Y3), .ALLRED_CYC(AR3), .CNT_W(8)
  ) dut3 (
    .clock          (clock),
    .reset_n        (reset_n),
    .demand         ({N3{1'b1}}),
    .preempt        (1'b0),
    .preempt_dir    (2'b00),
    .lamp           (lamp3),
    .active_dir     (active_dir3),
    .phase          (phase3),
    .preempt_active (preempt_active3)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3*N-1:0] lamp;
    logic [1:0]     phase;
    logic [1:0]     dir;
    logic           pa;
  } exp_t;

  typedef struct packed {
    logic [3*N3-1:0] lamp;
    logic [1:0]      phase;
    logic [1:0]      dir;
  } exp3_t;

  exp_t  exp_q[$];
  exp3_t exp3_q[$];

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cur;
  int           t3;
  bit           rand_dem;
  logic [N-1:0] fixed_dem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [2:0] color(input logic [1:0] ph);
    if (ph == PH_G) return 3'b001;
    if (ph == PH_Y) return 3'b010;
    return 3'b100;
  endfunction

  // Lamp vector for up to 8 approaches: only approach d shows the phase colour.
  function automatic logic [23:0] lamp_vec(input int n, input logic [1:0] ph, input int d);
    logic [23:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[3*i +: 3] = (i == d) ? color(ph) : 3'b100;
    return l;
  endfunction

  // First approach after c (wrapping) with demand; fixed-time step if none.
  function automatic int next_dir(input int c, input logic [N-1:0] dem);
    for (int k = 1; k <= N; k++) begin
      if (dem[(c + k) % N]) return (c + k) % N;
    end
    return (c + 1) % N;
  endfunction

  // dut3 under full demand: initial all-red, then fixed 10-clock slots.
  function automatic exp3_t model3(input int t);
    exp3_t       e;
    logic [23:0] l;
    int          u, r, d;
    logic [1:0]  ph;
    if (t < AR3) begin
      ph = PH_AR;
      d  = N3 - 1;
    end else begin
      u = t - AR3;
      r = u % (G3 + Y3 + AR3);
      d = (u / (G3 + Y3 + AR3)) % N3;
      ph = (r < G3) ? PH_G : (r < G3 + Y3) ? PH_Y : PH_AR;
    end
    l       = lamp_vec(N3, ph, d);
    e.lamp  = l[3*N3-1:0];
    e.phase = ph;
    e.dir   = 2'(d);
    return e;
  endfunction

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clock) begin
    exp_t  e;
    exp3_t e3;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lamp", 64'(lamp), 64'(e.lamp));
      check("phase", 64'(phase), 64'(e.phase));
      check("active_dir", 64'(active_dir), 64'(e.dir));
      check("preempt_active", 64'(preempt_active), 64'(e.pa));
    end
    if (reset_n && exp3_q.size() > 0) begin
      e3 = exp3_q.pop_front();
      check("lamp3", 64'(lamp3), 64'(e3.lamp));
      check("phase3", 64'(phase3), 64'(e3.phase));
      check("active_dir3", 64'(active_dir3), 64'(e3.dir));
    end
  end

  task automatic drive_inputs();
    demand = rand_dem ? N'($urandom) : fixed_dem;
`ifndef TRAFFIC_PREEMPT_EN
    preempt     = 1'($urandom);
    preempt_dir = 2'($urandom);
`endif
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic step(input logic [1:0] ph, input int d, input logic pa);
    exp_t        e;
    logic [23:0] l;
    l       = lamp_vec(N, ph, d);
    e.lamp  = l[3*N-1:0];
    e.phase = ph;
    e.dir   = 2'(d);
    e.pa    = pa;
    exp_q.push_back(e);
    exp3_q.push_back(model3(t3));
    t3++;
    @(posedge clock);
    #1;
  endtask

  // One service slot: all-red on cur, then green and yellow on the chosen
  // approach. Returns early (hit=1) at the start of green cycle hit_g of
  // approach hit_dir, without queueing that cycle.
  task automatic run_slot(input int hit_dir, input int hit_g, output bit hit);
    logic [N-1:0] sampled;
    hit     = 1'b0;
    sampled = '0;
    for (int c = 0; c < AR; c++) begin
      drive_inputs();
      sampled = demand;
      step(PH_AR, cur, 1'b0);
    end
    cur = next_dir(cur, sampled);
    for (int g = 0; g < G; g++) begin
      if (cur == hit_dir && g == hit_g) begin
        hit = 1'b1;
        return;
      end
      drive_inputs();
      step(PH_G, cur, 1'b0);
    end
    for (int y = 0; y < Y; y++) begin
      drive_inputs();
      step(PH_Y, cur, 1'b0);
    end
  endtask

  task automatic run_slots(input int n);
    bit hit;
    for (int i = 0; i < n; i++) run_slot(-1, 0, hit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    rand_dem  = 1'b0;
    fixed_dem = '1;

    // Reset values while reset is held.
    repeat (2) @(posedge clock);
    #1;
    check("reset_lamp", 64'(lamp), 64'h924);
    check("reset_phase", 64'(phase), 64'(PH_AR));
    check("reset_dir", 64'(active_dir), 64'(N - 1));
    check("reset_pa", 64'(preempt_active), 64'(0));
    check("reset_lamp3", 64'(lamp3), 64'h124);
    reset_n = 1'b1;
    cur     = N - 1;
    t3      = 0;

    // Full demand, 104 clocks: rotation 0,1,2,3,0,...
    fixed_dem = 4'b1111;
    run_slots(8);
    // Only approach 2 has demand.
    fixed_dem = 4'b0100;
    run_slots(4);
    // No demand: fixed-time rotation.
    fixed_dem = 4'b0000;
    run_slots(4);
    // Random demand.
    rand_dem = 1'b1;
    run_slots(20);
    rand_dem = 1'b0;

    // Asynchronous reset in the sixth green cycle of approach 1.
    fixed_dem = 4'b1111;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) run_slot(1, 5, hit);
    check("reset_point_reached", 64'(hit), 64'(1));
    if (hit) begin
      reset_n = 1'b0;
      #1;
      check("async_reset_lamp", 64'(lamp), 64'h924);
      check("async_reset_dir", 64'(active_dir), 64'(N - 1));
      check("async_reset_lamp3", 64'(lamp3), 64'h124);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      cur     = N - 1;
      t3      = 0;
    end
    run_slots(4);

`ifdef TRAFFIC_PREEMPT_EN
    // Preempt to approach 2 from approach 0's second green cycle, for 30 clocks.
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) run_slot(0, 1, hit);
    check("preempt_point_reached", 64'(hit), 64'(1));
    if (hit) begin
      preempt     = 1'b1;
      preempt_dir = 2'd2;
      step(PH_G, 0, 1'b0);
      repeat (Y) step(PH_Y, 0, 1'b1);
      repeat (AR) step(PH_AR, 0, 1'b1);
      repeat (30 - 1 - Y - AR) step(PH_G, 2, 1'b1);
      preempt = 1'b0;
      repeat (G) step(PH_G, 2, 1'b1);
      repeat (Y) step(PH_Y, 2, 1'b0);
      cur = 2;
    end
    run_slots(3);
`endif

    @(negedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size() + exp3_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
